// File: rtl/axi_single_beat_master.sv
// Single-beat AXI4 master bridging a read/write/done requester port; one transaction in flight.
// Define AXI_CTRL_ERR_EN to add the err output flagging SLVERR/DECERR responses.
module axi_single_beat_master #(
    parameter int unsigned     ID_W      = 4,
    parameter logic [ID_W-1:0] MASTER_ID = '0
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            read,
    input  logic            write,
    input  logic [31:0]     addr,
    input  logic [31:0]     store,
    input  logic            done,
    output logic            ready,
    output logic [31:0]     load,
`ifdef AXI_CTRL_ERR_EN
    output logic            err,
`endif
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RADDR = 3'd1;
    localparam logic [2:0] RDATA = 3'd2;
    localparam logic [2:0] WADDR = 3'd3;
    localparam logic [2:0] WRESP = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]  state;
    logic [31:0] addr_q;
    logic [31:0] store_q;
    logic [31:0] load_q;
    logic        aw_done;
    logic        w_done;
    logic        w_both;

    // The write phase ends once each channel has handshaken, in any order or together.
    assign w_both = (aw_done || awready) && (w_done || wready);

`ifdef AXI_CTRL_ERR_EN
    logic [1:0] resp_q;
    logic       unused_in;
    assign unused_in = ^{bid, rid, rlast};
`else
    logic       unused_in;
    assign unused_in = ^{bid, rid, rlast, bresp, rresp};
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            load_q  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef AXI_CTRL_ERR_EN
            resp_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (read) begin
                        addr_q <= addr;
                        state  <= RADDR;
                    end else if (write) begin
                        addr_q  <= addr;
                        store_q <= store;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WADDR;
                    end
                end
                RADDR: begin
                    if (arready) state <= RDATA;
                end
                RDATA: begin
                    if (rvalid) begin
                        load_q <= rdata;
`ifdef AXI_CTRL_ERR_EN
                        resp_q <= rresp;
`endif
                        state  <= DONE;
                    end
                end
                WADDR: begin
                    if (awready) aw_done <= 1'b1;
                    if (wready)  w_done  <= 1'b1;
                    if (w_both)  state   <= WRESP;
                end
                WRESP: begin
                    if (bvalid) begin
`ifdef AXI_CTRL_ERR_EN
                        resp_q <= bresp;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready   = (state == DONE);
    assign load    = load_q;
`ifdef AXI_CTRL_ERR_EN
    // SLVERR and DECERR both have bit 1 set.
    assign err     = (state == DONE) && resp_q[1];
`endif

    assign awid    = MASTER_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awvalid = (state == WADDR) && !aw_done;
    assign wdata   = store_q;
    assign wstrb   = 4'hF;
    assign wvalid  = (state == WADDR) && !w_done;
    assign wlast   = wvalid;
    assign bready  = (state == WRESP);

    assign arid    = MASTER_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arvalid = (state == RADDR);
    assign rready  = (state == RDATA);

endmodule

// File: tb/tb_axi_single_beat_master.sv
// Directed bench for axi_single_beat_master; the slave side is driven by hand, step by step.
module tb_axi_single_beat_master;

    logic        clk = 1'b0;
    logic        nrst;
    logic        read, write, done;
    logic [31:0] addr, store;
    logic        ready;
    logic [31:0] load;
`ifdef AXI_CTRL_ERR_EN
    logic        err;
`endif
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_single_beat_master #(.ID_W(4), .MASTER_ID(4'd0)) dut (
        .clk(clk), .nrst(nrst), .read(read), .write(write), .addr(addr), .store(store),
        .done(done), .ready(ready), .load(load),
`ifdef AXI_CTRL_ERR_EN
        .err(err),
`endif
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic done_pulse();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; read = 0; write = 0; done = 0; addr = '0; store = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00; bid = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00; rid = '0; rlast = 0;

        // Reset
        repeat (3) tick();
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid",  32'(wvalid),  32'd0);
        chk("rst_bready",  32'(bready),  32'd0);
        chk("rst_rready",  32'(rready),  32'd0);
        chk("rst_ready",   32'(ready),   32'd0);
        chk("rst_load",    load,         32'd0);
        nrst = 1'b1;
        tick();

        // Zero-wait read: ready after three edges
        read = 1; addr = 32'h0081_0000;
        tick();
        read = 0; addr = 32'h0;
        chk("rd_arvalid", 32'(arvalid), 32'd1);
        chk("rd_araddr",  araddr,       32'h0081_0000);
        chk("rd_arlen",   32'(arlen),   32'd0);
        chk("rd_arsize",  32'(arsize),  32'd2);
        chk("rd_arburst", 32'(arburst), 32'd1);
        chk("rd_arid",    32'(arid),    32'd0);
        arready = 1;
        tick();
        arready = 0;
        chk("rd_arvalid_drop", 32'(arvalid), 32'd0);
        chk("rd_rready",       32'(rready),  32'd1);
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        tick();
        rvalid = 0; rdata = 32'h0;
        chk("rd_ready", 32'(ready), 32'd1);
        chk("rd_load",  load,       32'hDEAD_BEEF);
        tick();
        chk("rd_ready_hold", 32'(ready), 32'd1);
        chk("rd_load_hold",  load,       32'hDEAD_BEEF);
        done_pulse();
        chk("rd_ready_clear", 32'(ready), 32'd0);

        // Write, awready one cycle before wready
        write = 1; addr = 32'h0082_0000; store = 32'h1234_5678;
        tick();
        write = 0; addr = 32'h0; store = 32'h0;
        chk("wr_awvalid", 32'(awvalid), 32'd1);
        chk("wr_wvalid",  32'(wvalid),  32'd1);
        chk("wr_awaddr",  awaddr,       32'h0082_0000);
        chk("wr_wdata",   wdata,        32'h1234_5678);
        chk("wr_wstrb",   32'(wstrb),   32'hF);
        chk("wr_wlast",   32'(wlast),   32'd1);
        chk("wr_awlen",   32'(awlen),   32'd0);
        awready = 1;
        tick();
        awready = 0;
        chk("wr_awvalid_drop", 32'(awvalid), 32'd0);
        chk("wr_wvalid_hold",  32'(wvalid),  32'd1);
        chk("wr_bready_early", 32'(bready),  32'd0);
        wready = 1;
        tick();
        wready = 0;
        chk("wr_wvalid_drop", 32'(wvalid), 32'd0);
        chk("wr_bready",      32'(bready), 32'd1);
        tick();
        chk("wr_bready_hold", 32'(bready), 32'd1);
        chk("wr_ready_early", 32'(ready),  32'd0);
        bvalid = 1;
        tick();
        bvalid = 0;
        chk("wr_ready",      32'(ready),  32'd1);
        chk("wr_bready_off", 32'(bready), 32'd0);
        done_pulse();
        chk("wr_ready_clear", 32'(ready), 32'd0);

        // Write with both handshakes in the same cycle
        write = 1; addr = 32'h0000_0040; store = 32'hA5A5_0001;
        tick();
        write = 0;
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        chk("wr2_bready",  32'(bready),  32'd1);
        chk("wr2_awvalid", 32'(awvalid), 32'd0);
        chk("wr2_wvalid",  32'(wvalid),  32'd0);
        bvalid = 1; bresp = 2'b10;
        tick();
        bvalid = 0; bresp = 2'b00;
        chk("wr2_ready", 32'(ready), 32'd1);
`ifdef AXI_CTRL_ERR_EN
        chk("wr2_err", 32'(err), 32'd1);
`endif
        done_pulse();

        // Backpressure on AR and R
        read = 1; addr = 32'h0083_0000;
        tick();
        read = 0; addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_arvalid", 32'(arvalid), 32'd1);
            chk("bp_araddr",  araddr,       32'h0083_0000);
        end
        arready = 1;
        tick();
        arready = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_rready", 32'(rready), 32'd1);
            chk("bp_ready",  32'(ready),  32'd0);
        end
        rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b10;
        tick();
        rvalid = 0; rresp = 2'b00;
        chk("bp_ready_set", 32'(ready), 32'd1);
        chk("bp_load",      load,       32'hCAFE_F00D);
`ifdef AXI_CTRL_ERR_EN
        chk("bp_err", 32'(err), 32'd1);
`endif
        done_pulse();
`ifdef AXI_CTRL_ERR_EN
        chk("bp_err_clear", 32'(err), 32'd0);
`endif

        // Read wins over write; request held through done re-issues
        read = 1; write = 1; addr = 32'h0000_1000; store = 32'h5555_5555;
        tick();
        chk("pri_arvalid", 32'(arvalid), 32'd1);
        chk("pri_awvalid", 32'(awvalid), 32'd0);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'h0BAD_F00D;
        tick();
        rvalid = 0;
        chk("pri_load", load, 32'h0BAD_F00D);
`ifdef AXI_CTRL_ERR_EN
        chk("pri_err_okay", 32'(err), 32'd0);
`endif
        write = 0; addr = 32'h0000_2000;
        done_pulse();
        chk("reissue_idle", 32'(ready), 32'd0);
        tick();
        chk("reissue_arvalid", 32'(arvalid), 32'd1);
        chk("reissue_araddr",  araddr,       32'h0000_2000);
        read = 0;

        // Asynchronous reset mid-transaction
        #2 nrst = 1'b0;
        #1;
        chk("arst_arvalid", 32'(arvalid), 32'd0);
        chk("arst_araddr",  araddr,       32'd0);
        chk("arst_load",    load,         32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
